// File: rtl/shared_mem_port.sv
// shared_mem_port: unified instr/data memory port for the multicycle core.
// Ports: fetch (fetch_req/pc -> instr, fetch_done), data
// (data_req/data_we/data_be/data_addr/wdata -> rdata, data_done),
// plus err (misaligned or out of range) and busy.
module shared_mem_port #(
  parameter int    DATA_W      = 32,
  parameter int    ADDR_W      = 32,
  parameter int    DEPTH       = 128,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   pc,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_be,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   instr,
  output logic [DATA_W-1:0]   rdata,
  output logic                fetch_done,
  output logic                data_done,
  output logic                err,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef struct packed {
    logic              ch;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      cnt_q;
  logic [3:0]      cnt_d;
  xfer_t           xq;
  xfer_t           xd;
  logic            acc;
  logic            fin;
  logic            bad;
  logic            st_ok;
  logic            any_done;
  logic [WA_W-1:0] widx;
  logic [IDX_W-1:0] idx;

  // Range check uses the full word address; truncation to
  // the storage index is only trusted once bad is clear.
  assign widx  = xq.addr[ADDR_W-1:2];
  assign bad   = (xq.addr[1:0] != 2'b00) ||
                 (widx >= WA_W'(DEPTH));
  assign idx   = widx[IDX_W-1:0];
  assign st_ok = fin && xq.ch && xq.we && !bad;
  assign busy  = (state_q != IDLE);

  // No accept while a done pulse is out: the requester is
  // still holding req for the transfer that just finished.
  assign any_done = fetch_done || data_done;

  always_comb begin
    xd = xq;
    priority case (1'b1)
      data_req: begin
        xd.ch    = 1'b1;
        xd.we    = data_we;
        xd.be    = data_be;
        xd.addr  = data_addr;
        xd.wdata = wdata;
      end
      fetch_req: begin
        xd.ch    = 1'b0;
        xd.we    = 1'b0;
        xd.be    = '0;
        xd.addr  = pc;
        xd.wdata = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc     = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((fetch_req || data_req) && !any_done) begin
          acc     = 1'b1;
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      xq         <= '0;
      instr      <= '0;
      rdata      <= '0;
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fetch_done <= fin && !xq.ch;
      data_done  <= fin && xq.ch;
      err        <= fin && bad;
      if (acc) begin
        xq <= xd;
      end
      if (fin && !xq.ch && !bad) begin
        instr <= mem[idx];
      end
      if (fin && xq.ch && !xq.we) begin
        rdata <= bad ? '0 : mem[idx];
      end
    end
  end

  // Storage has no reset; a reset mid-transfer forces IDLE
  // asynchronously, so st_ok can never fire for it.
  always_ff @(posedge clk) begin
    if (st_ok) begin
      for (int i = 0; i < BE_W; i++) begin
        if (xq.be[i]) begin
          mem[idx][8*i +: 8] <= xq.wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
